// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter.
// Turns a W-bit unsigned value into three packed BCD digits (hundreds, tens, ones),
// one shift per clock, using a start/done_tick handshake. Legal W is 1..9.
module bin2bcd_seq #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OP     = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] b_q, b_d;
  logic [3:0]   p2_q, p2_d;
  logic [3:0]   p1_q, p1_d;
  logic [3:0]   p0_q, p0_d;
  logic [3:0]   i_q, i_d;
  logic [3:0]   bcd2_q, bcd2_d;
  logic [3:0]   bcd1_q, bcd1_d;
  logic [3:0]   bcd0_q, bcd0_d;

  logic [3:0]   adj2, adj1, adj0;

  // Add-3 correction applied to every digit of 5 or more before each shift
  always_comb begin
    adj2 = (p2_q >= 4'd5) ? p2_q + 4'd3 : p2_q;
    adj1 = (p1_q >= 4'd5) ? p1_q + 4'd3 : p1_q;
    adj0 = (p0_q >= 4'd5) ? p0_q + 4'd3 : p0_q;
  end

  // Next-state logic: capture in IDLE, adjust-and-shift in OP, publish digits from DONE
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    p2_d    = p2_q;
    p1_d    = p1_q;
    p0_d    = p0_q;
    i_d     = i_q;
    bcd2_d  = bcd2_q;
    bcd1_d  = bcd1_q;
    bcd0_d  = bcd0_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = bin;
          p2_d    = 4'd0;
          p1_d    = 4'd0;
          p0_d    = 4'd0;
          i_d     = 4'(W);
          state_d = OP;
        end
      end
      OP: begin
        // The 13-bit {p2,p1,p0,b msb} shifts left; the top 12 bits become the new digits
        {p2_d, p1_d, p0_d} = {adj2[2:0], adj1, adj0, b_q[W-1]};
        b_d = b_q << 1;
        i_d = i_q - 4'd1;
        if (i_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd2_d  = p2_q;
        bcd1_d  = p1_q;
        bcd0_d  = p0_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      p2_q    <= 4'd0;
      p1_q    <= 4'd0;
      p0_q    <= 4'd0;
      i_q     <= 4'd0;
      bcd2_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd0_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      p0_q    <= p0_d;
      i_q     <= i_d;
      bcd2_q  <= bcd2_d;
      bcd1_q  <= bcd1_d;
      bcd0_q  <= bcd0_d;
    end
  end

  // Handshake outputs decoded straight from the state register, so they cannot overlap
  always_comb begin
    ready     = (state_q == IDLE);
    done_tick = (state_q == DONE);
    bcd2      = bcd2_q;
    bcd1      = bcd1_q;
    bcd0      = bcd0_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed plus randomized checks of bin2bcd_seq (W=7) against
// an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  localparam int W = 7;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         ready;
  logic         done_tick;
  logic [3:0]   bcd2, bcd1, bcd0;

  int          checks;
  int          failures;
  logic [11:0] lastResult;

  bin2bcd_seq #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of a value, computed with plain division
  function automatic logic [11:0] expBcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full conversion with latency, ready-window, stability and result checks
  task automatic applyStimulus(input int value, input string tag);
    logic [11:0] expected;
    int          cnt;
    int          readyLow;
    logic        stable;
    expected = expBcd(value);
    @(negedge clk);
    bin   = W'(value);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cnt      = 0;
    readyLow = 0;
    stable   = 1'b1;
    while (done_tick !== 1'b1 && cnt < 20) begin
      if ({bcd2, bcd1, bcd0} !== lastResult) stable = 1'b0;
      if (ready === 1'b0) readyLow++;
      @(negedge clk);
      cnt++;
    end
    if ({bcd2, bcd1, bcd0} !== lastResult) stable = 1'b0;
    if (ready === 1'b0) readyLow++;
    checkOutput({tag, "_latency"}, 12'(cnt), 12'(W));
    checkOutput({tag, "_readyLow"}, 12'(readyLow), 12'(W + 1));
    checkOutput({tag, "_stable"}, {11'd0, stable}, 12'd1);
    @(negedge clk);
    checkOutput({tag, "_bcd"}, {bcd2, bcd1, bcd0}, expected);
    checkOutput({tag, "_idle"}, {10'd0, ready, done_tick}, 12'b10);
    lastResult = expected;
  endtask

  initial begin
    int          binVal;
    logic [11:0] acc;
    int          cnt;
    checks     = 0;
    failures   = 0;
    lastResult = 12'd0;
    reset      = 1'b0;
    start      = 1'b1;
    bin        = 7'd99;

    // Reset overrides start; everything cleared
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_bcd", {bcd2, bcd1, bcd0}, 12'd0);
    checkOutput("reset_flags", {10'd0, ready, done_tick}, 12'b10);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", {10'd0, ready, done_tick}, 12'b10);

    // Directed values from the bring-up plan, including the upstream result 16
    applyStimulus(0, "zero");
    applyStimulus(127, "max");
    applyStimulus(99, "v99");
    applyStimulus(5, "v5");
    applyStimulus(16, "chain16");

    // Start held high with bin changing every cycle: accepts every W+2 cycles
    acc = 12'd0;
    for (int e = 0; e < 30; e++) begin
      binVal = int'($urandom_range(0, 127));
      bin    = W'(binVal);
      start  = 1'b1;
      if (e % 9 == 0) acc = expBcd(binVal);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("held_done_e%0d", e), {11'd0, done_tick}, {11'd0, (e % 9 == 7)});
      checkOutput($sformatf("held_ready_e%0d", e), {11'd0, ready}, {11'd0, (e % 9 == 8)});
      if (e % 9 == 8) begin
        checkOutput($sformatf("held_bcd_e%0d", e), {bcd2, bcd1, bcd0}, acc);
      end
    end
    start = 1'b0;
    cnt   = 0;
    while (ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("held_drain_timeout", {11'd0, ready}, 12'd1);
    checkOutput("held_last_bcd", {bcd2, bcd1, bcd0}, acc);
    lastResult = acc;

    // Abort a conversion of 42 three cycles in, after a 127 result
    applyStimulus(127, "pre_abort");
    @(negedge clk);
    bin   = 7'd42;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("abort_c0_done", {11'd0, done_tick}, 12'd0);
    @(negedge clk);
    checkOutput("abort_c1_done", {11'd0, done_tick}, 12'd0);
    @(negedge clk);
    checkOutput("abort_c2_bcd", {bcd2, bcd1, bcd0}, 12'h127);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_bcd", {bcd2, bcd1, bcd0}, 12'd0);
    checkOutput("abort_flags", {10'd0, ready, done_tick}, 12'b10);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_still_idle", {10'd0, ready, done_tick}, 12'b10);
    lastResult = 12'd0;
    applyStimulus(42, "after_abort");

    // Exhaustive sweep of the full input range
    for (int v = 0; v < 128; v++) begin
      applyStimulus(v, $sformatf("sweep%0d", v));
    end

    // A few random conversions to close out
    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(0, 127)), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
